// File: rtl/dram_port_arbiter_pkg.sv
// Shared types for the DRAM port arbiter: FSM states, operation encoding,
// and an index-width helper used to size grant/pointer fields.
package dram_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_t;

    // Width of an index into an n-entry vector (at least one bit).
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dram_port_arbiter_rr.sv
// Combinational round-robin picker: returns the first requester at or after
// the pointer, wrapping from N-1 back to 0.
module dram_port_arbiter_rr #(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [IW-1:0] o_grant,
    output logic          o_valid
);

    logic [IW-1:0] w_grant;
    logic          w_valid;
    int            w_idx;

    // Scan ports starting at the pointer; the first hit wins.
    always_comb begin
        w_grant = '0;
        w_valid = 1'b0;
        w_idx   = 0;
        for (int k = 0; k < N; k++) begin
            w_idx = ((int'(i_ptr) + k) >= N) ? (int'(i_ptr) + k - N) : (int'(i_ptr) + k);
            if (!w_valid && i_req[w_idx]) begin
                w_grant = IW'(w_idx);
                w_valid = 1'b1;
            end else begin
                w_grant = w_grant;
                w_valid = w_valid;
            end
        end
    end

    assign o_grant = w_grant;
    assign o_valid = w_valid;

endmodule

// File: rtl/dram_port_arbiter.sv
// N-port DRAM arbiter: serialises single-word read/write requests from the
// masters onto one SDRAM controller port with round-robin fairness, per-port
// write permission, a completion watchdog and per-port error pulses.
module dram_port_arbiter
    import dram_port_arbiter_pkg::*;
#(
    parameter int                   NUM_PORTS  = 2,
    parameter int                   ADDR_W     = 24,
    parameter int                   DATA_W     = 32,
    parameter logic [NUM_PORTS-1:0] WRITE_MASK = 2'b10,
    parameter int                   TIMEOUT    = 1023,
    localparam int                  GW         = idx_w(NUM_PORTS)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_PORTS*ADDR_W-1:0]   m_addr,
    input  logic [NUM_PORTS*DATA_W-1:0]   m_wdata,
    input  logic [NUM_PORTS-1:0]          m_req_read,
    input  logic [NUM_PORTS-1:0]          m_req_write,
    output logic [DATA_W-1:0]             m_rdata,
    output logic [NUM_PORTS-1:0]          m_data_valid,
    output logic [NUM_PORTS-1:0]          m_write_complete,
    output logic [NUM_PORTS-1:0]          m_error,
    output logic [ADDR_W-1:0]             dram_addr,
    output logic [DATA_W-1:0]             dram_data_in,
    output logic                          dram_req_read,
    output logic                          dram_req_write,
    input  logic [DATA_W-1:0]             dram_data_out,
    input  logic                          dram_data_out_valid,
    input  logic                          dram_write_complete,
    output logic                          busy,
    output logic [GW-1:0]                 grant_id
);

    // Watchdog counts 0..TIMEOUT-1 BUSY cycles; expiry on the TIMEOUT-th.
    localparam int              CW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam bit              WD_EN   = (TIMEOUT != 0);
    localparam logic [CW-1:0]   WD_LAST = CW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
    localparam logic [NUM_PORTS-1:0] ONE_1H = {{(NUM_PORTS-1){1'b0}}, 1'b1};

    state_t                 r_state;
    op_t                    r_op;
    logic [GW-1:0]          r_grant;
    logic [GW-1:0]          r_ptr;
    logic [CW-1:0]          r_wdog;
    logic [DATA_W-1:0]      r_rdata;
    logic [NUM_PORTS-1:0]   r_dv;
    logic [NUM_PORTS-1:0]   r_wc;
    logic [NUM_PORTS-1:0]   r_err;
    logic [ADDR_W-1:0]      r_addr;
    logic [DATA_W-1:0]      r_wdata;
    logic                   r_req_rd;
    logic                   r_req_wr;
    logic                   r_busy;

    logic [GW-1:0]          w_gnt;
    logic                   w_gnt_valid;
    logic [ADDR_W-1:0]      w_sel_addr;
    logic [DATA_W-1:0]      w_sel_wdata;
    logic                   w_sel_write;
    logic                   w_sel_wok;
    logic [NUM_PORTS-1:0]   w_gnt_1h;
    logic [NUM_PORTS-1:0]   w_cur_1h;

    dram_port_arbiter_rr #(
        .N  (NUM_PORTS),
        .IW (GW)
    ) u_rr (
        .i_req   (m_req_read | m_req_write),
        .i_ptr   (r_ptr),
        .o_grant (w_gnt),
        .o_valid (w_gnt_valid)
    );

    assign w_gnt_1h = ONE_1H << w_gnt;
    assign w_cur_1h = ONE_1H << r_grant;

    // Mux the winning port's address, data, op and write permission.
    always_comb begin
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        w_sel_write = 1'b0;
        w_sel_wok   = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (w_gnt == GW'(i)) begin
                w_sel_addr  = m_addr[i*ADDR_W +: ADDR_W];
                w_sel_wdata = m_wdata[i*DATA_W +: DATA_W];
                w_sel_write = m_req_write[i];
                w_sel_wok   = WRITE_MASK[i];
            end else begin
                w_sel_addr  = w_sel_addr;
                w_sel_wdata = w_sel_wdata;
                w_sel_write = w_sel_write;
                w_sel_wok   = w_sel_wok;
            end
        end
    end

    // Arbitration FSM with latched request, watchdog and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_op     <= OP_READ;
            r_grant  <= '0;
            r_ptr    <= '0;
            r_wdog   <= '0;
            r_rdata  <= '0;
            r_dv     <= '0;
            r_wc     <= '0;
            r_err    <= '0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_req_rd <= 1'b0;
            r_req_wr <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_gnt_valid) begin
                        r_grant <= w_gnt;
                        r_addr  <= w_sel_addr;
                        r_wdata <= w_sel_wdata;
                        r_wdog  <= '0;
                        r_busy  <= 1'b1;
                        if (w_sel_write) begin
                            r_op <= OP_WRITE;
                            if (w_sel_wok) begin
                                r_req_wr <= 1'b1;
                                r_state  <= ST_BUSY;
                            end else begin
                                // Read-only port: reject without touching DRAM.
                                r_wc    <= w_gnt_1h;
                                r_err   <= w_gnt_1h;
                                r_state <= ST_DONE;
                            end
                        end else begin
                            r_op     <= OP_READ;
                            r_req_rd <= 1'b1;
                            r_state  <= ST_BUSY;
                        end
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    if ((r_op == OP_READ) && dram_data_out_valid) begin
                        r_rdata  <= dram_data_out;
                        r_dv     <= w_cur_1h;
                        r_req_rd <= 1'b0;
                        r_state  <= ST_DONE;
                    end else if ((r_op == OP_WRITE) && dram_write_complete) begin
                        r_wc     <= w_cur_1h;
                        r_req_wr <= 1'b0;
                        r_state  <= ST_DONE;
                    end else if (WD_EN && (r_wdog == WD_LAST)) begin
                        // Controller never answered: abandon with an error.
                        r_req_rd <= 1'b0;
                        r_req_wr <= 1'b0;
                        r_err    <= w_cur_1h;
                        if (r_op == OP_READ) begin
                            r_dv <= w_cur_1h;
                        end else begin
                            r_wc <= w_cur_1h;
                        end
                        r_state <= ST_DONE;
                    end else if (WD_EN) begin
                        r_wdog <= r_wdog + CW'(1);
                    end else begin
                        r_wdog <= r_wdog;
                    end
                end
                ST_DONE: begin
                    // One quiet cycle so a stale held request is not re-granted.
                    r_dv    <= '0;
                    r_wc    <= '0;
                    r_err   <= '0;
                    r_busy  <= 1'b0;
                    r_ptr   <= (r_grant == GW'(NUM_PORTS - 1)) ? '0 : (r_grant + GW'(1));
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_req_rd <= 1'b0;
                    r_req_wr <= 1'b0;
                    r_busy   <= 1'b0;
                    r_state  <= ST_IDLE;
                end
            endcase
        end
    end

    assign m_rdata          = r_rdata;
    assign m_data_valid     = r_dv;
    assign m_write_complete = r_wc;
    assign m_error          = r_err;
    assign dram_addr        = r_addr;
    assign dram_data_in     = r_wdata;
    assign dram_req_read    = r_req_rd;
    assign dram_req_write   = r_req_wr;
    assign busy             = r_busy;
    assign grant_id         = r_grant;

endmodule

// File: tb/tb_dram_port_arbiter.sv
// Directed bench: a 2-port arbiter with an 8-cycle watchdog and a 4-port
// arbiter with the watchdog disabled, sharing clock and reset.
module tb_dram_port_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---- 2-port instance ----
    logic [47:0] a_addr = '0;
    logic [63:0] a_wdata = '0;
    logic [1:0]  a_rreq = '0, a_wreq = '0;
    logic [31:0] a_rdata, a_din, a_dout = '0;
    logic [1:0]  a_dv, a_wc, a_err;
    logic [23:0] a_daddr;
    logic        a_dreq_rd, a_dreq_wr, a_dval = 1'b0, a_dwc = 1'b0, a_busy;
    logic        a_gid;

    dram_port_arbiter #(.NUM_PORTS(2), .ADDR_W(24), .DATA_W(32),
                        .WRITE_MASK(2'b10), .TIMEOUT(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .m_addr(a_addr), .m_wdata(a_wdata),
        .m_req_read(a_rreq), .m_req_write(a_wreq), .m_rdata(a_rdata),
        .m_data_valid(a_dv), .m_write_complete(a_wc), .m_error(a_err),
        .dram_addr(a_daddr), .dram_data_in(a_din), .dram_req_read(a_dreq_rd),
        .dram_req_write(a_dreq_wr), .dram_data_out(a_dout),
        .dram_data_out_valid(a_dval), .dram_write_complete(a_dwc),
        .busy(a_busy), .grant_id(a_gid));

    // ---- 4-port instance ----
    logic [95:0]  b_addr = '0;
    logic [127:0] b_wdata = '0;
    logic [3:0]   b_rreq = '0, b_wreq = '0;
    logic [31:0]  b_rdata, b_din, b_dout = '0;
    logic [3:0]   b_dv, b_wc, b_err;
    logic [23:0]  b_daddr;
    logic         b_dreq_rd, b_dreq_wr, b_dval = 1'b0, b_dwc = 1'b0, b_busy;
    logic [1:0]   b_gid;

    dram_port_arbiter #(.NUM_PORTS(4), .ADDR_W(24), .DATA_W(32),
                        .WRITE_MASK(4'b1111), .TIMEOUT(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .m_addr(b_addr), .m_wdata(b_wdata),
        .m_req_read(b_rreq), .m_req_write(b_wreq), .m_rdata(b_rdata),
        .m_data_valid(b_dv), .m_write_complete(b_wc), .m_error(b_err),
        .dram_addr(b_daddr), .dram_data_in(b_din), .dram_req_read(b_dreq_rd),
        .dram_req_write(b_dreq_wr), .dram_data_out(b_dout),
        .dram_data_out_valid(b_dval), .dram_write_complete(b_dwc),
        .busy(b_busy), .grant_id(b_gid));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Grant on next edge, controller answers after lat cycles of request.
    task automatic serve_a(input int g, input logic [31:0] d, input int lat);
        tick();
        chk("a_grant", 64'(a_gid), 64'(g));
        chk("a_req_rd_on", 64'(a_dreq_rd), 64'd1);
        for (int k = 1; k < lat; k++) begin
            tick();
            chk("a_req_rd_hold", 64'(a_dreq_rd), 64'd1);
        end
        a_dout = d; a_dval = 1'b1;
        tick();
        a_dval = 1'b0;
        chk("a_dv_pulse", 64'(a_dv), 64'd1 << g);
        chk("a_rdata", 64'(a_rdata), 64'(d));
        chk("a_err_none", 64'(a_err), 64'd0);
        chk("a_req_rd_off", 64'(a_dreq_rd), 64'd0);
        tick();
        chk("a_dv_clear", 64'(a_dv), 64'd0);
        chk("a_busy_done", 64'(a_busy), 64'd0);
    endtask

    task automatic serve_b(input int g, input logic [31:0] d);
        tick();
        chk("b_grant", 64'(b_gid), 64'(g));
        chk("b_req_rd_on", 64'(b_dreq_rd), 64'd1);
        b_dout = d; b_dval = 1'b1;
        tick();
        b_dval = 1'b0;
        chk("b_dv_pulse", 64'(b_dv), 64'd1 << g);
        chk("b_rdata", 64'(b_rdata), 64'(d));
        tick();
        chk("b_dv_clear", 64'(b_dv), 64'd0);
    endtask

    initial begin
        // Reset state
        tick(); tick();
        chk("rst_busy", 64'(a_busy), 64'd0);
        chk("rst_req", 64'({a_dreq_rd, a_dreq_wr}), 64'd0);
        chk("rst_rdata", 64'(a_rdata), 64'd0);
        chk("rst_pulses", 64'({a_dv, a_wc, a_err}), 64'd0);
        chk("rst_b_grant", 64'(b_gid), 64'd0);
        rst_n = 1'b1;
        tick();

        // 1: single read on port 1, controller answers after 5 cycles
        a_addr[47:24] = 24'h000123;
        a_rreq = 2'b10;
        serve_a(1, 32'hDEADBEEF, 5);
        a_rreq = 2'b00;
        chk("t1_addr", 64'(a_daddr), 64'h000123);

        // 2: both ports read continuously -> 0,1,0,1
        a_rreq = 2'b11;
        serve_a(0, 32'h11111111, 1);
        serve_a(1, 32'h22222222, 1);
        serve_a(0, 32'h33333333, 1);
        serve_a(1, 32'h44444444, 1);
        a_rreq = 2'b00;

        // 3a: write on read-only port 0 is rejected
        a_wdata[31:0] = 32'hAAAA5555;
        a_wreq = 2'b01;
        tick();
        chk("t3_wc_rej", 64'(a_wc), 64'd1);
        chk("t3_err_rej", 64'(a_err), 64'd1);
        chk("t3_no_dram_wr", 64'(a_dreq_wr), 64'd0);
        a_wreq = 2'b00;
        tick();
        chk("t3_pulse_clear", 64'({a_wc, a_err}), 64'd0);

        // 3b: write on port 1 reaches the controller; wrong-type strobe ignored
        a_addr[47:24] = 24'h000456;
        a_wdata[63:32] = 32'h12345678;
        a_wreq = 2'b10;
        tick();
        chk("t3_dram_wr", 64'(a_dreq_wr), 64'd1);
        chk("t3_din", 64'(a_din), 64'h12345678);
        chk("t3_daddr", 64'(a_daddr), 64'h000456);
        a_dval = 1'b1;
        tick();
        a_dval = 1'b0;
        chk("t3_wrong_strobe", 64'({a_dreq_wr, a_dv, a_wc}), 64'h10);
        a_dwc = 1'b1;
        tick();
        a_dwc = 1'b0;
        chk("t3_wc_ok", 64'(a_wc), 64'd2);
        chk("t3_err_ok", 64'(a_err), 64'd0);
        chk("t3_wr_drop", 64'(a_dreq_wr), 64'd0);
        a_wreq = 2'b00;
        tick();

        // 4: watchdog expiry on port 0 read
        a_rreq = 2'b01;
        tick();
        chk("t4_req_on", 64'(a_dreq_rd), 64'd1);
        for (int k = 1; k < 8; k++) tick();
        chk("t4_req_held7", 64'(a_dreq_rd), 64'd1);
        tick();
        chk("t4_req_drop", 64'(a_dreq_rd), 64'd0);
        chk("t4_dv", 64'(a_dv), 64'd1);
        chk("t4_err", 64'(a_err), 64'd1);
        chk("t4_rdata_keep", 64'(a_rdata), 64'h44444444);
        a_rreq = 2'b00;
        tick();

        // 4b: done strobe coincident with expiry -> done wins, no error
        a_rreq = 2'b10;
        tick();
        for (int k = 1; k < 8; k++) tick();
        a_dout = 32'h0BADF00D; a_dval = 1'b1;
        tick();
        a_dval = 1'b0;
        chk("t4b_dv", 64'(a_dv), 64'd2);
        chk("t4b_err", 64'(a_err), 64'd0);
        chk("t4b_rdata", 64'(a_rdata), 64'h0BADF00D);
        a_rreq = 2'b00;
        tick();

        // 5: 4 ports, pointer moved to 2, stray strobe in IDLE
        b_dval = 1'b1; b_dout = 32'hFFFFFFFF;
        tick();
        b_dval = 1'b0;
        chk("t5_stray", 64'({b_dv, b_busy}), 64'd0);
        b_rreq = 4'b0010;
        serve_b(1, 32'hB0000001);
        b_rreq = 4'b1111;
        serve_b(2, 32'hB0000002);
        serve_b(3, 32'hB0000003);
        serve_b(0, 32'hB0000004);
        serve_b(1, 32'hB0000005);
        b_rreq = 4'b0000;

        // 6: reset while BUSY
        a_rreq = 2'b01;
        serve_a(0, 32'h55555555, 1);
        a_rreq = 2'b10;
        tick();
        chk("t6_busy_pre", 64'({a_busy, a_dreq_rd}), 64'h3);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_req_drop", 64'(a_dreq_rd), 64'd0);
        chk("t6_busy_drop", 64'(a_busy), 64'd0);
        chk("t6_no_pulse", 64'({a_dv, a_err}), 64'd0);
        a_rreq = 2'b00;
        tick();
        rst_n = 1'b1;
        tick();
        a_rreq = 2'b11;
        serve_a(0, 32'h66666666, 1);
        a_rreq = 2'b00;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "time limit");
    end

endmodule
